// File: rtl/mem_rd_wr_arbiter_pkg.sv
// mem_rd_wr_arbiter_pkg: arbiter state encodings, one-hot grant and response constants
package mem_rd_wr_arbiter_pkg;
    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_IFU_AR,
        ARB_IFU_R,
        ARB_LSU_AR,
        ARB_LSU_R,
        ARB_LSU_AW,
        ARB_LSU_B
    } arb_state_t;
    localparam logic [2:0] GRANT_IFU    = 3'b001;
    localparam logic [2:0] GRANT_LSU_RD = 3'b010;
    localparam logic [2:0] GRANT_LSU_WR = 3'b100;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
endpackage

// File: rtl/mem_rd_wr_arbiter_arb_pick.sv
// mem_rd_wr_arbiter_arb_pick: picks the next owner from IDLE; fixed LSU-first priority,
// or IFU/LSU round-robin when MEM_ARB_RR_EN is defined.
module mem_rd_wr_arbiter_arb_pick
    import mem_rd_wr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic       ifu_arvalid,
    input  logic       lsu_arvalid,
    input  logic       lsu_awvalid,
    input  logic       lsu_wvalid,
    output logic [2:0] next_state
);
    logic lsu_wr, lsu_req, lsu_win;
    assign lsu_wr  = lsu_awvalid && lsu_wvalid;
    assign lsu_req = lsu_wr || lsu_arvalid;
`ifdef MEM_ARB_RR_EN
    logic last_owner;  // 1 when the LSU owned the previous transaction
    assign lsu_win = lsu_req && !(ifu_arvalid && last_owner);
    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= 1'b0;
        else if (idle && (lsu_req || ifu_arvalid))
            last_owner <= lsu_win;
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, idle};
    assign lsu_win   = lsu_req;
`endif
    assign next_state = lsu_win ? (lsu_wr ? ARB_LSU_AW : ARB_LSU_AR) :
                        ifu_arvalid ? ARB_IFU_AR : ARB_IDLE;
endmodule

// File: rtl/mem_rd_wr_arbiter.sv
// mem_rd_wr_arbiter: shares one AXI4-Lite-style slave between IFU (read) and LSU (read/write),
// one transaction at a time; MEM_ARB_RR_EN selects round-robin arbitration in the picker.
module mem_rd_wr_arbiter
    import mem_rd_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    input  logic                  ifu_rready,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [1:0]            ifu_rresp,
    input  logic [DATA_WIDTH-1:0] lsu_araddr,
    input  logic [DATA_WIDTH-1:0] lsu_awaddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [STRB_WIDTH-1:0] lsu_wstrb,
    input  logic                  lsu_arvalid,
    input  logic                  lsu_rready,
    input  logic                  lsu_awvalid,
    input  logic                  lsu_wvalid,
    input  logic                  lsu_bready,
    output logic                  lsu_arready,
    output logic                  lsu_rvalid,
    output logic                  lsu_awready,
    output logic                  lsu_wready,
    output logic                  lsu_bvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic [1:0]            lsu_bresp,
    output logic [DATA_WIDTH-1:0] mem_araddr,
    output logic [DATA_WIDTH-1:0] mem_awaddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic                  mem_arvalid,
    output logic                  mem_rready,
    output logic                  mem_awvalid,
    output logic                  mem_wvalid,
    output logic                  mem_bready,
    input  logic                  mem_arready,
    input  logic                  mem_rvalid,
    input  logic                  mem_awready,
    input  logic                  mem_wready,
    input  logic                  mem_bvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            mem_rresp,
    input  logic [1:0]            mem_bresp,
    output logic [2:0]            grant
);
    arb_state_t state, state_n;
    logic [2:0] pick;
    logic aw_done, w_done, aw_fire, w_fire;

    mem_rd_wr_arbiter_arb_pick u_pick (
        .clk         (clk),
        .rst         (rst),
        .idle        (state == ARB_IDLE),
        .ifu_arvalid (ifu_arvalid),
        .lsu_arvalid (lsu_arvalid),
        .lsu_awvalid (lsu_awvalid),
        .lsu_wvalid  (lsu_wvalid),
        .next_state  (pick)
    );

    // Each write channel is offered to the slave only until its own handshake completes
    assign aw_fire = state == ARB_LSU_AW && lsu_awvalid && !aw_done && mem_awready;
    assign w_fire  = state == ARB_LSU_AW && lsu_wvalid && !w_done && mem_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= state_n == ARB_LSU_AW && (aw_done || aw_fire);
            w_done  <= state_n == ARB_LSU_AW && (w_done || w_fire);
        end
    end

    always_comb begin
        state_n     = state;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = RESP_OKAY;
        lsu_bresp   = RESP_OKAY;
        mem_araddr  = '0;
        mem_awaddr  = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awvalid = 1'b0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        case (state)
            ARB_IDLE: state_n = arb_state_t'(pick);
            ARB_IFU_AR: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
                if (ifu_arvalid && mem_arready) state_n = ARB_IFU_R;
            end
            ARB_IFU_R: begin
                ifu_rvalid = mem_rvalid;
                ifu_rdata  = mem_rdata;
                ifu_rresp  = mem_rresp;
                mem_rready = ifu_rready;
                if (mem_rvalid && ifu_rready) state_n = ARB_IDLE;
            end
            ARB_LSU_AR: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
                if (lsu_arvalid && mem_arready) state_n = ARB_LSU_R;
            end
            ARB_LSU_R: begin
                lsu_rvalid = mem_rvalid;
                lsu_rdata  = mem_rdata;
                lsu_rresp  = mem_rresp;
                mem_rready = lsu_rready;
                if (mem_rvalid && lsu_rready) state_n = ARB_IDLE;
            end
            ARB_LSU_AW: begin
                mem_awaddr  = lsu_awaddr;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_awvalid = lsu_awvalid && !aw_done;
                mem_wvalid  = lsu_wvalid && !w_done;
                lsu_awready = mem_awready && !aw_done;
                lsu_wready  = mem_wready && !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = ARB_LSU_B;
            end
            ARB_LSU_B: begin
                lsu_bvalid = mem_bvalid;
                lsu_bresp  = mem_bresp;
                mem_bready = lsu_bready;
                if (mem_bvalid && lsu_bready) state_n = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign grant = {state == ARB_LSU_AW || state == ARB_LSU_B,
                    state == ARB_LSU_AR || state == ARB_LSU_R,
                    state == ARB_IFU_AR || state == ARB_IFU_R};
endmodule
